sar_ctrl_10b: RTL and testbench

SAR_CTRL_10B -- requirements
Module: sar_ctrl_10b

---
 rtl/sar_ctrl_10b.sv | 142 ++++++++++++++
 tb/tb_sar_ctrl_10b.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/sar_ctrl_10b.sv
// SAR ADC sequencer: track/sample, binary-search bit trials against a
// handshaked comparator with per-trial timeout, and an end-of-conversion pulse.
module sar_ctrl_10b #(
  parameter int unsigned NBITS         = 10,
  parameter int unsigned SAMPLE_CYCLES = 2,
  parameter int unsigned TIMEOUT       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cont,
  input  logic             comp_result,
  input  logic             comp_done,
  output logic             sample,
  output logic [NBITS-1:0] dac_code,
  output logic [NBITS-1:0] data_out,
  output logic             eoc,
  output logic             busy,
  output logic             timeout_err
);

  localparam int unsigned IW = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam int unsigned SW = $clog2(SAMPLE_CYCLES + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [NBITS-1:0] ONE = NBITS'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SAMPLE  = 2'd1,
    S_CONVERT = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t           state, state_d;
  logic [NBITS-1:0] work, work_d;
  logic [NBITS-1:0] data_d, dac_d;
  logic [IW-1:0]    idx, idx_d;
  logic [SW-1:0]    scnt, scnt_d;
  logic [TW-1:0]    wcnt, wcnt_d;
  logic             err_d;
  logic             resolve, bit_val;

  // State register plus datapath; outputs registered from next-state values
  // so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      work        <= '0;
      idx         <= '0;
      scnt        <= '0;
      wcnt        <= '0;
      sample      <= 1'b0;
      dac_code    <= '0;
      data_out    <= '0;
      eoc         <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_d;
      work        <= work_d;
      idx         <= idx_d;
      scnt        <= scnt_d;
      wcnt        <= wcnt_d;
      sample      <= (state_d == S_SAMPLE);
      dac_code    <= dac_d;
      data_out    <= data_d;
      eoc         <= (state_d == S_DONE);
      busy        <= (state_d != S_IDLE);
      timeout_err <= err_d;
    end
  end

  // Next-state, trial resolution and next output values.
  always_comb begin
    state_d = state;
    work_d  = work;
    idx_d   = idx;
    scnt_d  = scnt;
    wcnt_d  = wcnt;
    data_d  = data_out;
    err_d   = timeout_err;
    dac_d   = '0;
    resolve = 1'b0;
    bit_val = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_d = S_SAMPLE;
          scnt_d  = '0;
          err_d   = 1'b0;
        end
      end
      S_SAMPLE: begin
        if (scnt == SW'(SAMPLE_CYCLES - 1)) begin
          state_d = S_CONVERT;
          work_d  = '0;
          idx_d   = IW'(NBITS - 1);
          wcnt_d  = '0;
        end else begin
          scnt_d = scnt + SW'(1);
        end
      end
      S_CONVERT: begin
        // A missing comparator answer forces the bit to 0 after TIMEOUT cycles.
        if (comp_done) begin
          resolve = 1'b1;
          bit_val = comp_result;
        end else if (wcnt == TW'(TIMEOUT - 1)) begin
          resolve = 1'b1;
          err_d   = 1'b1;
        end else begin
          wcnt_d = wcnt + TW'(1);
        end
        if (resolve) begin
          work_d[idx] = bit_val;
          wcnt_d      = '0;
          if (idx == '0) begin
            state_d = S_DONE;
            data_d  = work_d;
          end else begin
            idx_d = idx - IW'(1);
          end
        end
      end
      S_DONE: begin
        if (cont || start) begin
          state_d = S_SAMPLE;
          scnt_d  = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_CONVERT) begin
      dac_d = work_d | (ONE << idx_d);
    end
  end

endmodule

// File: tb/tb_sar_ctrl_10b.sv
// Directed bench for sar_ctrl_10b with a behavioural comparator model.
module tb_sar_ctrl_10b;

  logic       clk = 1'b0;
  logic       rst, start, cont, comp_result, comp_done;
  logic       sample, eoc, busy, timeout_err;
  logic [9:0] dac_code, data_out;

  int         checks   = 0;
  int         failures = 0;

  logic [9:0] vin;
  int         done_mode;  // 0: done every cycle, 1: 3 idle cycles per trial, 2: stuck 0
  int         gap;
  logic [9:0] dac_seq [10];
  int         ndac;

  sar_ctrl_10b #(.NBITS(10), .SAMPLE_CYCLES(2), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .start(start), .cont(cont),
    .comp_result(comp_result), .comp_done(comp_done),
    .sample(sample), .dac_code(dac_code), .data_out(data_out),
    .eoc(eoc), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Comparator model: decides on the stable DAC code at the falling edge.
  always @(negedge clk) begin
    comp_result = (vin >= dac_code);
    case (done_mode)
      0: comp_done = 1'b1;
      1: begin
        if (dac_code == 10'h000) begin
          gap = 0; comp_done = 1'b0;
        end else if (gap < 3) begin
          comp_done = 1'b0; gap++;
        end else begin
          comp_done = 1'b1; gap = 0;
        end
      end
      default: comp_done = 1'b0;
    endcase
  end

  // One conversion from IDLE; k counts cycles after the start edge.
  task automatic do_conv(input logic [9:0] v, input int mode, input bit hammer,
                         output logic [9:0] dat, output int lat,
                         output int neoc, output int nsamp);
    vin = v; done_mode = mode; lat = -1; neoc = 0; nsamp = 0; ndac = 0;
    @(negedge clk); start = 1'b1;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      start = hammer && (dac_code != 10'h000);
      if (sample) nsamp++;
      if (dac_code != 10'h000 && ndac < 10) begin dac_seq[ndac] = dac_code; ndac++; end
      if (eoc) begin neoc++; if (lat < 0) lat = k; end
      if (lat >= 0 && k >= lat + 3) break;
    end
    start = 1'b0;
    dat = data_out;
    if (lat < 0) begin
      checks++; failures++;
      $display("FAIL conv_bound no eoc within 300 cycles, required one");
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; cont = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (sample !== 1'b0) begin failures++; $display("FAIL reset_sample got=%b exp=0", sample); end
    checks++; if (dac_code !== 10'h000) begin failures++; $display("FAIL reset_dac got=%h exp=000", dac_code); end
    checks++; if (data_out !== 10'h000) begin failures++; $display("FAIL reset_data got=%h exp=000", data_out); end
    checks++; if (eoc !== 1'b0) begin failures++; $display("FAIL reset_eoc got=%b exp=0", eoc); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", timeout_err); end
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_basic();
    logic [9:0] d; int lat, ne, ns;
    do_conv(10'h2A5, 0, 1'b0, d, lat, ne, ns);
    checks++; if (d !== 10'h2A5) begin failures++; $display("FAIL basic_data got=%h exp=2a5", d); end
    checks++; if (lat != 13) begin failures++; $display("FAIL basic_latency got=%0d exp=13", lat); end
    checks++; if (ne != 1) begin failures++; $display("FAIL basic_eoc_count got=%0d exp=1", ne); end
    checks++; if (ns != 2) begin failures++; $display("FAIL basic_sample_cycles got=%0d exp=2", ns); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_idle got=%b exp=0", busy); end
  endtask

  task automatic test_extremes();
    logic [9:0] d; logic [9:0] exp_dac; int lat, ne, ns;
    do_conv(10'h3FF, 0, 1'b0, d, lat, ne, ns);
    checks++; if (d !== 10'h3FF) begin failures++; $display("FAIL full_data got=%h exp=3ff", d); end
    do_conv(10'h000, 0, 1'b0, d, lat, ne, ns);
    checks++; if (d !== 10'h000) begin failures++; $display("FAIL zero_data got=%h exp=000", d); end
    checks++; if (ndac != 10) begin failures++; $display("FAIL zero_trials got=%0d exp=10", ndac); end
    for (int j = 0; j < 10; j++) begin
      exp_dac = 10'h200 >> j;
      checks++;
      if (dac_seq[j] !== exp_dac) begin
        failures++; $display("FAIL zero_dac_seq[%0d] got=%h exp=%h", j, dac_seq[j], exp_dac);
      end
    end
  endtask

  task automatic test_slow_done();
    logic [9:0] d; int lat, ne, ns;
    do_conv(10'h155, 1, 1'b0, d, lat, ne, ns);
    checks++; if (d !== 10'h155) begin failures++; $display("FAIL slow_data got=%h exp=155", d); end
    checks++; if (lat != 43) begin failures++; $display("FAIL slow_latency got=%0d exp=43", lat); end
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL slow_err got=%b exp=0", timeout_err); end
  endtask

  task automatic test_start_ignored();
    logic [9:0] d; int lat, ne, ns;
    do_conv(10'h0F0, 0, 1'b1, d, lat, ne, ns);
    checks++; if (d !== 10'h0F0) begin failures++; $display("FAIL ign_data got=%h exp=0f0", d); end
    checks++; if (lat != 13) begin failures++; $display("FAIL ign_latency got=%0d exp=13", lat); end
    checks++; if (ne != 1) begin failures++; $display("FAIL ign_eoc_count got=%0d exp=1", ne); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ign_idle got=%b exp=0", busy); end
  endtask

  task automatic test_back_to_back();
    int et [4]; int ne, idle_seen;
    int exp_et;
    vin = 10'h2A5; done_mode = 0; cont = 1'b1; ne = 0; idle_seen = 0;
    for (int j = 0; j < 4; j++) et[j] = -1;
    @(negedge clk); start = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      start = (dac_code != 10'h000);
      if (k == 40) cont = 1'b0;
      if (eoc) begin if (ne < 4) et[ne] = k; ne++; end
      if (k <= 52 && busy !== 1'b1) idle_seen++;
    end
    start = 1'b0;
    for (int j = 0; j < 4; j++) begin
      exp_et = 13 * (j + 1);
      checks++;
      if (et[j] != exp_et) begin failures++; $display("FAIL b2b_eoc[%0d] got=%0d exp=%0d", j, et[j], exp_et); end
    end
    checks++; if (ne != 4) begin failures++; $display("FAIL b2b_eoc_count got=%0d exp=4", ne); end
    checks++; if (idle_seen != 0) begin failures++; $display("FAIL b2b_gap got=%0d exp=0", idle_seen); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_final_idle got=%b exp=0", busy); end
    checks++; if (data_out !== 10'h2A5) begin failures++; $display("FAIL b2b_data got=%h exp=2a5", data_out); end
  endtask

  task automatic test_reset_mid();
    logic [9:0] d; int lat, ne, ns, nconv;
    vin = 10'h155; done_mode = 0; nconv = 0;
    @(negedge clk); start = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (dac_code != 10'h000) nconv++;
      if (nconv == 5) begin rst = 1'b1; break; end
    end
    checks++; if (nconv != 5) begin failures++; $display("FAIL mid_reach got=%0d exp=5", nconv); end
    @(negedge clk); rst = 1'b0;
    checks++; if (sample !== 1'b0) begin failures++; $display("FAIL mid_sample got=%b exp=0", sample); end
    checks++; if (dac_code !== 10'h000) begin failures++; $display("FAIL mid_dac got=%h exp=000", dac_code); end
    checks++; if (data_out !== 10'h000) begin failures++; $display("FAIL mid_data got=%h exp=000", data_out); end
    checks++; if (eoc !== 1'b0) begin failures++; $display("FAIL mid_eoc got=%b exp=0", eoc); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_busy got=%b exp=0", busy); end
    do_conv(10'h155, 0, 1'b0, d, lat, ne, ns);
    checks++; if (d !== 10'h155) begin failures++; $display("FAIL mid_fresh_data got=%h exp=155", d); end
    checks++; if (lat != 13) begin failures++; $display("FAIL mid_fresh_latency got=%0d exp=13", lat); end
  endtask

  task automatic test_timeout();
    logic [9:0] d; int lat, ne, ns;
    do_conv(10'h3FF, 2, 1'b0, d, lat, ne, ns);
    checks++; if (d !== 10'h000) begin failures++; $display("FAIL to_data got=%h exp=000", d); end
    checks++; if (lat != 83) begin failures++; $display("FAIL to_latency got=%0d exp=83", lat); end
    checks++; if (timeout_err !== 1'b1) begin failures++; $display("FAIL to_err got=%b exp=1", timeout_err); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL to_idle got=%b exp=0", busy); end
    repeat (3) @(negedge clk);
    checks++; if (timeout_err !== 1'b1) begin failures++; $display("FAIL to_sticky got=%b exp=1", timeout_err); end
    do_conv(10'h2A5, 0, 1'b0, d, lat, ne, ns);
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL to_clear_by_start got=%b exp=0", timeout_err); end
    checks++; if (d !== 10'h2A5) begin failures++; $display("FAIL to_recover_data got=%h exp=2a5", d); end
    do_conv(10'h3FF, 2, 1'b0, d, lat, ne, ns);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL to_clear_by_rst got=%b exp=0", timeout_err); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cont = 1'b0;
    comp_result = 1'b0; comp_done = 1'b0;
    vin = 10'h000; done_mode = 0; gap = 0; ndac = 0;
    test_reset();
    test_basic();
    test_extremes();
    test_slow_done();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
